// File: rtl/eu_pkg.sv
// Shared definitions for the MCL51 execution-unit microsequencer:
// microword field layout, word types, jump sources and gate conditions.
package eu_pkg;

    localparam logic [2:0] TYPE_NOP  = 3'd0;
    localparam logic [2:0] TYPE_JUMP = 3'd1;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_NZ     = 3'd1;
    localparam logic [2:0] COND_Z      = 3'd2;
    localparam logic [2:0] COND_EXT0   = 3'd3;

    localparam int TYPE_HI  = 30;
    localparam int TYPE_LO  = 28;
    localparam int CALL_BIT = 24;
    localparam int SRC_HI   = 22;
    localparam int SRC_LO   = 20;
    localparam int COND_HI  = 18;
    localparam int COND_LO  = 16;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    typedef enum logic [2:0] {
        SRC_IMM     = 3'd0,
        SRC_DISP    = 3'd1,
        SRC_EA      = 3'd2,
        SRC_RET     = 3'd3,
        SRC_DISP8   = 3'd4,
        SRC_LOOPSET = 3'd5,
        SRC_DJNZ    = 3'd6,
        SRC_RSVD    = 3'd7
    } src_e;

    typedef struct packed {
        logic [2:0]  typ;
        logic        call;
        src_e        src;
        logic [2:0]  cond;
        logic [15:0] imm;
    } uword_t;

    function automatic uword_t decode(input logic [31:0] w);
        uword_t u;
        u.typ  = w[TYPE_HI:TYPE_LO];
        u.call = w[CALL_BIT];
        u.src  = src_e'(w[SRC_HI:SRC_LO]);
        u.cond = w[COND_HI:COND_LO];
        u.imm  = w[IMM_HI:IMM_LO];
        return u;
    endfunction

endpackage

// File: rtl/eu_call_stack.sv
// Microcode call stack: shift register with zero fill, top at entry 0.
// Overflow drops the oldest entry; underflow returns 0; both set a sticky error.
module eu_call_stack
    import eu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 10,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic          CORE_CLK,
    input  logic          RST_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          err
);

    logic [W-1:0]  stk_q [DEPTH];
    logic [W-1:0]  stk_d [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;

    // Next stack contents, occupancy and error flag
    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stk_d[i] = stk_q[i-1];
            end
            stk_d[0] = din;
            if (depth_q == DW'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                depth_d = depth_q + DW'(1);
            end
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stk_d[i] = stk_q[i+1];
            end
            stk_d[DEPTH-1] = '0;
            if (depth_q == '0) begin
                err_d = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
            end
        end
    end

    // Stack state registers
    always_ff @(posedge CORE_CLK) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stk_q   <= stk_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign top   = stk_q[0];
    assign depth = depth_q;
    assign err   = err_q;

endmodule

// File: rtl/eu_useq.sv
// MCL51 EU microsequencer: next-address mux with zero-bubble jumps,
// call stack, hardware loop counter, external conditions and HOLD freeze.
module eu_useq
    import eu_pkg::*;
#(
    parameter int UADDR_W      = 10,
    parameter int STACK_DEPTH  = 2,
    parameter int LOOP_W       = 8,
    parameter int NUM_EXT_COND = 4,
    parameter logic [UADDR_W-1:0] RESET_ADDR = 'h100,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    CORE_CLK,
    input  logic                    RST_n,
    output logic [UADDR_W-1:0]      UROM_ADDR,
    input  logic [31:0]             UROM_DATA,
    input  logic [7:0]              DISPATCH_DATA,
    input  logic [3:0]              EA_NIBBLE,
    input  logic                    ALU_ZERO,
    input  logic [NUM_EXT_COND-1:0] COND_IN,
    input  logic                    HOLD,
    output logic                    ISSUE,
    output logic                    NEW_INSTRUCTION,
    output logic [DW-1:0]           CALL_DEPTH,
    output logic                    STACK_ERR
);

    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [UADDR_W-1:0] upc_inc, target, stk_top;
    logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d, loop_dec;
    uword_t             uw;
    logic               gate, jump, branch, push, pop;
    logic               unused_bits;

    assign uw      = decode(UROM_DATA);
    assign ISSUE   = !HOLD;
    assign upc_inc = upc_q + UADDR_W'(1);

    assign unused_bits = ^{UROM_DATA, uw};

    // Jump gate from ALU zero flag or an external condition
    always_comb begin
        gate = 1'b0;
        case (uw.cond)
            COND_ALWAYS: gate = 1'b1;
            COND_NZ:     gate = !ALU_ZERO;
            COND_Z:      gate = ALU_ZERO;
            default: begin
                for (int k = 0; k < NUM_EXT_COND; k++) begin
                    if (uw.cond == 3'(k + 3)) begin
                        gate = COND_IN[k];
                    end
                end
            end
        endcase
    end

    // Jump source decode: target, stack and loop-counter actions
    always_comb begin
        jump       = ISSUE && (uw.typ == TYPE_JUMP) && gate;
        target     = upc_inc;
        branch     = 1'b0;
        pop        = 1'b0;
        loop_dec   = loop_cnt_q - LOOP_W'(1);
        loop_cnt_d = loop_cnt_q;
        if (jump) begin
            case (uw.src)
                SRC_IMM: begin
                    branch = 1'b1;
                    target = uw.imm[UADDR_W-1:0];
                end
                SRC_DISP: begin
                    branch = 1'b1;
                    target = UADDR_W'(DISPATCH_DATA);
                end
                SRC_EA: begin
                    branch = 1'b1;
                    target = {uw.imm[UADDR_W-1:4], EA_NIBBLE};
                end
                SRC_RET: begin
                    branch = 1'b1;
                    pop    = 1'b1;
                    target = stk_top;
                end
                SRC_DISP8: begin
                    branch = 1'b1;
                    target = {uw.imm[UADDR_W-5:0],
                              DISPATCH_DATA[2:0], 1'b0};
                end
                SRC_LOOPSET: begin
                    loop_cnt_d = uw.imm[LOOP_W-1:0];
                end
                SRC_DJNZ: begin
                    loop_cnt_d = loop_dec;
                    branch     = (loop_dec != '0);
                    target     = uw.imm[UADDR_W-1:0];
                end
                default: ;
            endcase
        end
        push = branch && uw.call && (uw.src != SRC_RET);
    end

    // Next ROM address: reset, then HOLD re-fetch, then branch, else step
    always_comb begin
        if (!RST_n) begin
            UROM_ADDR = RESET_ADDR;
        end else if (HOLD) begin
            UROM_ADDR = upc_q;
        end else if (branch) begin
            UROM_ADDR = target;
        end else begin
            UROM_ADDR = upc_inc;
        end
        upc_d = UROM_ADDR;
    end

    // upc tracks the word on UROM_DATA; loop counter state
    always_ff @(posedge CORE_CLK) begin
        if (!RST_n) begin
            upc_q      <= RESET_ADDR;
            loop_cnt_q <= '0;
        end else begin
            upc_q      <= upc_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end

    assign NEW_INSTRUCTION = ISSUE && (upc_q[UADDR_W-1:UADDR_W-2] == 2'b00);

    eu_call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UADDR_W)
    ) u_stack (
        .CORE_CLK (CORE_CLK),
        .RST_n    (RST_n),
        .push     (push),
        .pop      (pop),
        .din      (upc_inc),
        .top      (stk_top),
        .depth    (CALL_DEPTH),
        .err      (STACK_ERR)
    );

endmodule

// File: tb/tb_eu_useq.sv
// Bench for eu_useq: a synchronous ROM model runs short microprograms
// and a queue of expected per-cycle addresses and stack state is checked.
module tb_eu_useq;
    import eu_pkg::*;

    logic        CORE_CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [9:0]  UROM_ADDR;
    logic [31:0] UROM_DATA = '0;
    logic [7:0]  DISPATCH_DATA = '0;
    logic [3:0]  EA_NIBBLE = '0;
    logic        ALU_ZERO = 1'b0;
    logic [3:0]  COND_IN = '0;
    logic        HOLD = 1'b0;
    logic        ISSUE;
    logic        NEW_INSTRUCTION;
    logic [1:0]  CALL_DEPTH;
    logic        STACK_ERR;

    logic [31:0] rom [1024];

    typedef struct {
        logic [9:0] addr;
        logic [1:0] depth;
        logic       err;
        logic       issue;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    eu_useq #(
        .UADDR_W      (10),
        .STACK_DEPTH  (2),
        .LOOP_W       (8),
        .NUM_EXT_COND (4),
        .RESET_ADDR   (10'h100)
    ) dut (
        .CORE_CLK        (CORE_CLK),
        .RST_n           (RST_n),
        .UROM_ADDR       (UROM_ADDR),
        .UROM_DATA       (UROM_DATA),
        .DISPATCH_DATA   (DISPATCH_DATA),
        .EA_NIBBLE       (EA_NIBBLE),
        .ALU_ZERO        (ALU_ZERO),
        .COND_IN         (COND_IN),
        .HOLD            (HOLD),
        .ISSUE           (ISSUE),
        .NEW_INSTRUCTION (NEW_INSTRUCTION),
        .CALL_DEPTH      (CALL_DEPTH),
        .STACK_ERR       (STACK_ERR)
    );

    always #5 CORE_CLK = ~CORE_CLK;

    always @(posedge CORE_CLK) UROM_DATA <= rom[UROM_ADDR];

    function automatic logic [31:0] jw(input logic [2:0] src,
                                       input logic [2:0] cond,
                                       input logic call,
                                       input logic [15:0] imm);
        return {1'b0, 3'd1, 3'd0, call, 1'b0, src, 1'b0, cond, imm};
    endfunction

    task automatic expect_cyc(input logic [9:0] a, input logic [1:0] d,
                              input logic e, input logic i);
        exp_t x;
        x.addr = a;
        x.depth = d;
        x.err = e;
        x.issue = i;
        q.push_back(x);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    task automatic reset_to();
        @(negedge CORE_CLK);
        RST_n = 1'b0;
        HOLD = 1'b0;
        repeat (2) @(negedge CORE_CLK);
        #1;
    endtask

    task automatic step(input string name, input logic hold);
        exp_t x;
        @(negedge CORE_CLK);
        RST_n = 1'b1;
        HOLD = hold;
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = q.pop_front();
            if (UROM_ADDR !== x.addr) begin
                errors++;
                $display("FAIL %s addr: got %h want %h",
                         name, UROM_ADDR, x.addr);
            end
            checks++;
            if (CALL_DEPTH !== x.depth) begin
                errors++;
                $display("FAIL %s depth: got %0d want %0d",
                         name, CALL_DEPTH, x.depth);
            end
            checks++;
            if (STACK_ERR !== x.err) begin
                errors++;
                $display("FAIL %s err: got %b want %b",
                         name, STACK_ERR, x.err);
            end
            checks++;
            if (ISSUE !== x.issue) begin
                errors++;
                $display("FAIL %s issue: got %b want %b",
                         name, ISSUE, x.issue);
            end
        end
    endtask

    task automatic test_reset();
        clear_rom();
        reset_to();
        checks++;
        if (UROM_ADDR !== 10'h100 || CALL_DEPTH !== 2'd0 ||
            STACK_ERR !== 1'b0 || ISSUE !== 1'b1) begin
            errors++;
            $display("FAIL reset: addr %h d %0d e %b i %b want 100 0 0 1",
                     UROM_ADDR, CALL_DEPTH, STACK_ERR, ISSUE);
        end
        HOLD = 1'b1;
        #1;
        checks++;
        if (UROM_ADDR !== 10'h100 || ISSUE !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: addr %h i %b want 100 0",
                     UROM_ADDR, ISSUE);
        end
        HOLD = 1'b0;
        expect_cyc(10'h101, 0, 0, 1);
        expect_cyc(10'h102, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step("seq", 1'b0);
            checks++;
            if (NEW_INSTRUCTION !== 1'b0) begin
                errors++;
                $display("FAIL seq_ni: got %b want 0", NEW_INSTRUCTION);
            end
        end
    endtask

    task automatic test_dispatch();
        logic ni_exp [3];
        ni_exp = '{1'b0, 1'b0, 1'b1};
        clear_rom();
        rom[10'h101] = jw(SRC_DISP, COND_ALWAYS, 1'b0, 16'h0);
        DISPATCH_DATA = 8'h75;
        reset_to();
        expect_cyc(10'h101, 0, 0, 1);
        expect_cyc(10'h075, 0, 0, 1);
        expect_cyc(10'h076, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step("dispatch", 1'b0);
            checks++;
            if (NEW_INSTRUCTION !== ni_exp[i]) begin
                errors++;
                $display("FAIL dispatch_ni%0d: got %b want %b",
                         i, NEW_INSTRUCTION, ni_exp[i]);
            end
        end
    endtask

    task automatic test_targets();
        clear_rom();
        rom[10'h100] = jw(SRC_EA, COND_ALWAYS, 1'b0, 16'h02A0);
        rom[10'h2A5] = jw(SRC_DISP8, COND_ALWAYS, 1'b0, 16'h0012);
        EA_NIBBLE = 4'h5;
        DISPATCH_DATA = 8'h0D;
        reset_to();
        expect_cyc(10'h2A5, 0, 0, 1);
        expect_cyc(10'h12A, 0, 0, 1);
        expect_cyc(10'h12B, 0, 0, 1);
        repeat (3) step("targets", 1'b0);
    endtask

    task automatic test_calls();
        clear_rom();
        rom[10'h100] = jw(SRC_IMM, COND_ALWAYS, 1'b0, 16'h0110);
        rom[10'h110] = jw(SRC_IMM, COND_ALWAYS, 1'b1, 16'h0210);
        rom[10'h210] = jw(SRC_IMM, COND_ALWAYS, 1'b1, 16'h0310);
        rom[10'h310] = jw(SRC_IMM, COND_ALWAYS, 1'b1, 16'h0050);
        rom[10'h050] = jw(SRC_RET, COND_ALWAYS, 1'b0, 16'h0);
        rom[10'h311] = jw(SRC_RET, COND_ALWAYS, 1'b0, 16'h0);
        rom[10'h211] = jw(SRC_RET, COND_ALWAYS, 1'b0, 16'h0);
        reset_to();
        expect_cyc(10'h110, 0, 0, 1);
        expect_cyc(10'h210, 0, 0, 1);
        expect_cyc(10'h310, 1, 0, 1);
        expect_cyc(10'h050, 2, 0, 1);
        expect_cyc(10'h311, 2, 1, 1);
        expect_cyc(10'h211, 1, 1, 1);
        expect_cyc(10'h000, 0, 1, 1);
        expect_cyc(10'h001, 0, 1, 1);
        repeat (8) step("calls", 1'b0);
        reset_to();
        checks++;
        if (UROM_ADDR !== 10'h100 || CALL_DEPTH !== 2'd0 ||
            STACK_ERR !== 1'b0) begin
            errors++;
            $display("FAIL midreset: addr %h d %0d e %b want 100 0 0",
                     UROM_ADDR, CALL_DEPTH, STACK_ERR);
        end
    endtask

    task automatic test_loop();
        clear_rom();
        rom[10'h100] = jw(SRC_IMM, COND_ALWAYS, 1'b0, 16'h0120);
        rom[10'h120] = jw(SRC_LOOPSET, COND_ALWAYS, 1'b0, 16'h0003);
        rom[10'h122] = jw(SRC_DJNZ, COND_ALWAYS, 1'b0, 16'h0121);
        reset_to();
        expect_cyc(10'h120, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            expect_cyc(10'h121, 0, 0, 1);
            expect_cyc(10'h122, 0, 0, 1);
        end
        expect_cyc(10'h123, 0, 0, 1);
        expect_cyc(10'h124, 0, 0, 1);
        repeat (9) step("loop", 1'b0);
    endtask

    task automatic test_djnz_wrap();
        clear_rom();
        rom[10'h100] = jw(SRC_DJNZ, COND_ALWAYS, 1'b0, 16'h0140);
        reset_to();
        expect_cyc(10'h140, 0, 0, 1);
        expect_cyc(10'h141, 0, 0, 1);
        repeat (2) step("djnz_wrap", 1'b0);
    endtask

    task automatic test_cond();
        clear_rom();
        rom[10'h100] = jw(SRC_IMM, COND_ALWAYS, 1'b0, 16'h0130);
        rom[10'h130] = jw(SRC_IMM, 3'd3, 1'b0, 16'h01A0);
        rom[10'h131] = jw(SRC_IMM, 3'd7, 1'b0, 16'h01B0);
        rom[10'h1A0] = jw(SRC_IMM, COND_Z, 1'b0, 16'h01C0);
        rom[10'h1C0] = jw(SRC_IMM, COND_NZ, 1'b0, 16'h01D0);
        COND_IN = 4'hE;
        ALU_ZERO = 1'b1;
        reset_to();
        expect_cyc(10'h130, 0, 0, 1);
        expect_cyc(10'h131, 0, 0, 1);
        expect_cyc(10'h132, 0, 0, 1);
        repeat (3) step("cond_off", 1'b0);
        COND_IN = 4'h1;
        reset_to();
        expect_cyc(10'h130, 0, 0, 1);
        expect_cyc(10'h1A0, 0, 0, 1);
        expect_cyc(10'h1C0, 0, 0, 1);
        expect_cyc(10'h1C1, 0, 0, 1);
        repeat (4) step("cond_on", 1'b0);
        ALU_ZERO = 1'b0;
        COND_IN = 4'h0;
    endtask

    task automatic test_hold();
        clear_rom();
        rom[10'h100] = jw(SRC_IMM, COND_ALWAYS, 1'b0, 16'h0150);
        rom[10'h150] = jw(SRC_IMM, COND_ALWAYS, 1'b1, 16'h0160);
        rom[10'h160] = jw(SRC_RET, COND_ALWAYS, 1'b0, 16'h0);
        reset_to();
        expect_cyc(10'h150, 0, 0, 1);
        step("hold", 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_cyc(10'h150, 0, 0, 0);
            step("hold_on", 1'b1);
        end
        expect_cyc(10'h160, 0, 0, 1);
        expect_cyc(10'h151, 1, 0, 1);
        expect_cyc(10'h152, 0, 0, 1);
        repeat (3) step("hold_off", 1'b0);
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_targets();
        test_calls();
        test_loop();
        test_djnz_wrap();
        test_cond();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eu_useq.md
# eu_useq

Parametrised microsequencer for the MCL51 execution unit. It computes the next microcode ROM address with zero-bubble jumps and keeps a configurable-depth call stack. It adds a hardware loop counter, external condition inputs and a HOLD freeze. It sits between the synchronous microcode ROM and the EU datapath, and gates datapath writeback through ISSUE.

## Interface
Parameters:
- UADDR_W, 10: microcode address width, legal range 10..16.
- STACK_DEPTH, 2: call stack entries, ≥1.
- LOOP_W, 8: loop counter width, 1..16.
- NUM_EXT_COND, 4: external condition inputs, 1..5.
- RESET_ADDR, 'h100: first microword executed after reset.

Ports:
- CORE_CLK in 1: core clock.
- RST_n in 1: reset, synchronous, active-low; clock CORE_CLK.
- UROM_ADDR out UADDR_W: combinational ROM address, sampled by the ROM on the CORE_CLK edge.
- UROM_DATA in 32: ROM word, one-cycle latency. Fields: type[30:28], call[24], src[22:20], cond[18:16], imm[15:0].
- DISPATCH_DATA in 8: fetched 8051 opcode byte from the BIU.
- EA_NIBBLE in 4: EA decode nibble, r0[11:8] of the datapath.
- ALU_ZERO in 1: datapath last ALU result == 0.
- COND_IN in NUM_EXT_COND: external condition flags.
- HOLD in 1: freeze request from the BIU.
- ISSUE out 1: current UROM_DATA word executes this cycle.
- NEW_INSTRUCTION out 1: ISSUE && upc[UADDR_W-1:UADDR_W-2]==0.
- CALL_DEPTH out $clog2(STACK_DEPTH+1): number of occupied stack entries.
- STACK_ERR out 1: sticky flag for stack overflow or underflow.

## Operation
- upc register holds the address of the word currently on UROM_DATA.
- Every cycle: upc <= UROM_ADDR.
- ISSUE = !HOLD.
- Jump word is type==1. A jump is taken when ISSUE is 1 and the gate is true.
- Gate by cond:
  - 0: always.
  - 1: !ALU_ZERO.
  - 2: ALU_ZERO.
  - 3+k: COND_IN[k]. If k ≥ NUM_EXT_COND, the gate is never true.
- src values (apply only when taken):
  - 0: target imm[UADDR_W-1:0].
  - 1: target zero-extended DISPATCH_DATA.
  - 2: target {imm[UADDR_W-1:4], EA_NIBBLE}.
  - 3: return; target = stack top, then pop.
  - 4: target {imm[UADDR_W-5:0], DISPATCH_DATA[2:0], 1'b0}.
  - 5: LOOPSET; loop_cnt <= imm[LOOP_W-1:0], no address change.
  - 6: DJNZ; loop_cnt <= loop_cnt-1, and target imm if (loop_cnt-1)!=0.
  - 7: reserved; sequential.
- call=1 on a taken jump pushes upc+1. call is ignored for src 3/5/7, and for src 6 when not branching.
- UROM_ADDR priority:
  1. Reset: RESET_ADDR.
  2. HOLD: upc (re-fetch the same word).
  3. Taken branch: target.
  4. Otherwise: upc+1, modulo 2^UADDR_W.
- Non-jump types: the sequencer only advances; the datapath owns them.
- Stack is a shift register with 0 fill.
  - Push when full: oldest entry dropped, depth stays STACK_DEPTH, STACK_ERR set.
  - Pop when empty: target 0, depth stays 0, STACK_ERR set.
- DJNZ with loop_cnt==0: wraps to all-ones and branches.
- HOLD freezes upc, stack, loop_cnt and STACK_ERR, with no side effects. A held jump is evaluated once HOLD drops.

## Timing
- Reset values:
  - UROM_ADDR = RESET_ADDR, upc = RESET_ADDR.
  - ISSUE follows HOLD.
  - CALL_DEPTH = 0, STACK_ERR = 0, loop_cnt = 0, stack entries = 0.
- First cycle after reset release: UROM_DATA = ROM[RESET_ADDR].
- Taken jump at cycle n: target word is on UROM_DATA at n+1, with no bubble.
- Return at n+1 after a call at n: resumes at call address+1 at n+2.
- CALL_DEPTH and STACK_ERR update on the edge ending the issuing cycle.
- Reset mid-stream (any cycle, including during HOLD or a call): all state returns to reset values at the next edge.
- Critical path: UROM_DATA → gate/target mux → UROM_ADDR → ROM. No registered target.

## Structure
- eu_pkg holds:
  - type constants: NOP=0, JUMP=1.
  - src encodings (SRC_IMM … SRC_DJNZ).
  - cond encodings.
  - field bit positions for UROM_DATA.
- Sub-module eu_call_stack (params DEPTH, W), ports push, pop, din, top, depth, err.
- Top-level holds upc, loop_cnt, gate logic and the next-address mux.

## Test plan
- Reset, then sequential words: UROM_ADDR is 0x100 during reset, then 0x101, 0x102. ISSUE=1. NEW_INSTRUCTION=0.
- Word at 0x101 = dispatch jump, DISPATCH_DATA=0x75: next UROM_ADDR 0x075, NEW_INSTRUCTION=1 on the following cycle.
- STACK_DEPTH=2, three nested calls from 0x110/0x210/0x310, then three returns:
  - CALL_DEPTH goes 1,2,2 and STACK_ERR sets on the third call.
  - Returns go to 0x311, 0x211, then 0x000.
- LOOPSET imm=3 at 0x120, DJNZ imm=0x121 at 0x122: 0x121 executes 3 times total, then falls through to 0x123.
- cond=3 jump with COND_IN[0]=0 → 0x131. With 1 → imm. cond=7 with NUM_EXT_COND=4 is never taken.
- HOLD=1 for 3 cycles on a call word: UROM_ADDR held at upc, CALL_DEPTH unchanged, ISSUE=0. The call executes exactly once after HOLD drops.
